// File: rtl/mmio_hub_gen.sv
// MMIO hub: decodes FPro-bus accesses into N_SLOT slot strobes, returns
// registered read data with a valid strobe, and logs bad accesses.
// Optional macro MMIO_HUB_PIPE_EN adds an input register stage (latency 2).
// Ports: clk, reset (async, active low), mmio_* bus side,
// slot_* core side, err_irq (sticky error level).
module mmio_hub_gen #(
  parameter int          N_SLOT    = 16,
  parameter int          REG_AW    = 5,
  parameter logic [63:0] SLOT_MASK = 64'h013F,
  parameter int          HUB_SLOT  = N_SLOT - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mmio_cs,
  input  logic                 mmio_wr,
  input  logic                 mmio_rd,
  input  logic [20:0]          mmio_addr,
  input  logic [31:0]          mmio_wr_data,
  output logic [31:0]          mmio_rd_data,
  output logic                 mmio_rd_valid,
  output logic [N_SLOT-1:0]    slot_cs,
  output logic [N_SLOT-1:0]    slot_rd,
  output logic [N_SLOT-1:0]    slot_wr,
  output logic [REG_AW-1:0]    slot_reg_addr,
  output logic [31:0]          slot_wr_data,
  input  logic [N_SLOT*32-1:0] slot_rd_data,
  output logic                 err_irq
);

  localparam int SW = $clog2(N_SLOT);
  localparam logic [SW-1:0] HUB_IDX = SW'(HUB_SLOT);

  logic        s_cs;
  logic        s_rd;
  logic        s_wr;
  logic [20:0] s_addr;
  logic [31:0] s_wdata;

`ifdef MMIO_HUB_PIPE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_cs    <= 1'b0;
      s_rd    <= 1'b0;
      s_wr    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
    end else begin
      s_cs    <= mmio_cs;
      s_rd    <= mmio_rd;
      s_wr    <= mmio_wr;
      s_addr  <= mmio_addr;
      s_wdata <= mmio_wr_data;
    end
  end
`else
  assign s_cs    = mmio_cs;
  assign s_rd    = mmio_rd;
  assign s_wr    = mmio_wr;
  assign s_addr  = mmio_addr;
  assign s_wdata = mmio_wr_data;
`endif

  logic [REG_AW-1:0] reg_idx;
  logic [SW-1:0]     slot;
  logic              upper_ok;
  logic              is_hub;
  logic              mapped;
  logic              acc;
  logic              ill;
  logic              err;
  logic              ext;
  logic [N_SLOT-1:0] onehot;

  assign reg_idx  = s_addr[REG_AW-1:0];
  assign slot     = s_addr[REG_AW +: SW];
  assign upper_ok = (s_addr[20:REG_AW+SW] == '0);
  assign is_hub   = (slot == HUB_IDX);
  assign mapped   = upper_ok & (SLOT_MASK[slot] | is_hub);
  assign acc      = s_cs & (s_rd ^ s_wr);
  assign ill      = s_cs & s_rd & s_wr;
  assign err      = ill | (acc & ~mapped);
  // The hub slot is served internally and never strobes an external core.
  assign ext      = acc & mapped & ~is_hub & reset;
  assign onehot   = {{(N_SLOT-1){1'b0}}, 1'b1} << slot;

  assign slot_cs       = {N_SLOT{ext}} & onehot;
  assign slot_rd       = slot_cs & {N_SLOT{s_rd}};
  assign slot_wr       = slot_cs & {N_SLOT{s_wr}};
  assign slot_reg_addr = reg_idx;
  assign slot_wr_data  = s_wdata;

  logic        sticky;
  logic        sat;
  logic [20:0] err_addr;
  logic [15:0] err_cnt;
  logic [31:0] acc_cnt;
  logic        hub_wr;
  logic        clr0;
  logic        clr1;
  logic        sat_set;

  assign hub_wr  = acc & s_wr & mapped & is_hub;
  assign clr0    = hub_wr & (reg_idx == REG_AW'(0)) & s_wdata[0];
  assign clr1    = hub_wr & (reg_idx == REG_AW'(0)) & s_wdata[1];
  assign sat_set = err & (err_cnt >= 16'hFFFE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky   <= 1'b0;
      sat      <= 1'b0;
      err_addr <= '0;
      err_cnt  <= '0;
      acc_cnt  <= '0;
    end else begin
      // A new error beats a same-cycle clear.
      sticky <= err | (sticky & ~clr0);
      sat    <= sat_set | (sat & ~clr1);
      if (err && (!sticky || clr0))
        err_addr <= s_addr;
      if (hub_wr && reg_idx == REG_AW'(2))
        err_cnt <= '0;
      else if (err && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
      if (hub_wr && reg_idx == REG_AW'(3))
        acc_cnt <= '0;
      else if (acc)
        acc_cnt <= acc_cnt + 32'd1;
    end
  end

  assign err_irq = sticky;

  logic [31:0] hub_val;
  logic [31:0] rsp_data;
  logic        bad_rd;
  logic        hub_rd;
  logic        rsp_vld;

  always_comb begin
    hub_val = '0;
    case (reg_idx)
      REG_AW'(0): hub_val = {30'd0, sat, sticky};
      REG_AW'(1): hub_val = {11'd0, err_addr};
      REG_AW'(2): hub_val = {16'd0, err_cnt};
      REG_AW'(3): hub_val = acc_cnt;
      default:    hub_val = '0;
    endcase
  end

  assign bad_rd  = ill | (acc & s_rd & ~mapped);
  assign hub_rd  = acc & s_rd & mapped & is_hub;
  assign rsp_vld = ill | (acc & s_rd);

  always_comb begin
    rsp_data = '0;
    unique case (1'b1)
      bad_rd:  rsp_data = 32'hFFFF_FFFF;
      hub_rd:  rsp_data = hub_val;
      default: rsp_data = slot_rd_data[32*int'(slot) +: 32];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mmio_rd_valid <= 1'b0;
      mmio_rd_data  <= '0;
    end else begin
      mmio_rd_valid <= rsp_vld;
      if (rsp_vld)
        mmio_rd_data <= rsp_data;
    end
  end

endmodule

// File: tb/tb_mmio_hub_gen.sv
// Testbench for mmio_hub_gen: table vectors plus hand sequences,
// read responses checked through a scoreboard queue.
module tb_mmio_hub_gen;

`ifdef MMIO_HUB_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         reset;
  logic         mmio_cs;
  logic         mmio_wr;
  logic         mmio_rd;
  logic [20:0]  mmio_addr;
  logic [31:0]  mmio_wr_data;
  logic [31:0]  mmio_rd_data;
  logic         mmio_rd_valid;
  logic [15:0]  slot_cs;
  logic [15:0]  slot_rd;
  logic [15:0]  slot_wr;
  logic [4:0]   slot_reg_addr;
  logic [31:0]  slot_wr_data;
  logic [511:0] slot_rd_data;
  logic         err_irq;

  mmio_hub_gen dut (
    .clk           (clk),
    .reset         (reset),
    .mmio_cs       (mmio_cs),
    .mmio_wr       (mmio_wr),
    .mmio_rd       (mmio_rd),
    .mmio_addr     (mmio_addr),
    .mmio_wr_data  (mmio_wr_data),
    .mmio_rd_data  (mmio_rd_data),
    .mmio_rd_valid (mmio_rd_valid),
    .slot_cs       (slot_cs),
    .slot_rd       (slot_rd),
    .slot_wr       (slot_wr),
    .slot_reg_addr (slot_reg_addr),
    .slot_wr_data  (slot_wr_data),
    .slot_rd_data  (slot_rd_data),
    .err_irq       (err_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    int          due;
  } rsp_t;
  rsp_t sb[$];

  typedef struct {
    logic [15:0] cs;
    logic [15:0] rd;
    logic [15:0] wr;
    logic [4:0]  ra;
    logic [31:0] wd;
  } stb_t;
  stb_t prev_s;

  typedef struct {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [20:0] addr;
    logic [31:0] wd;
    logic [15:0] ecs;
    logic        ersp;
    logic [31:0] edata;
  } vec_t;

  localparam logic [20:0] HUB = 21'(15 * 32);

  function automatic logic [20:0] A(input int s, input int r);
    return 21'(s * 32 + r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic step(input logic cs, input logic rd, input logic wr,
                      input logic [20:0] addr, input logic [31:0] wd,
                      input logic [15:0] ecs, input logic ersp,
                      input logic [31:0] edata);
    stb_t now;
    stb_t cur;
    @(posedge clk);
    #1;
    mmio_cs      = cs;
    mmio_rd      = rd;
    mmio_wr      = wr;
    mmio_addr    = addr;
    mmio_wr_data = wd;
    if (ersp) sb.push_back('{edata, cyc + LAT});
    if (cs && (rd ^ wr)) exp_acc++;
    now.cs = ecs;
    now.rd = (rd && !wr) ? ecs : 16'h0;
    now.wr = (wr && !rd) ? ecs : 16'h0;
    now.ra = addr[4:0];
    now.wd = wd;
    @(negedge clk);
    cur = (LAT == 1) ? now : prev_s;
    prev_s = now;
    chk("slot_cs", {16'h0, slot_cs}, {16'h0, cur.cs});
    chk("slot_rd", {16'h0, slot_rd}, {16'h0, cur.rd});
    chk("slot_wr", {16'h0, slot_wr}, {16'h0, cur.wr});
    if (cur.cs != 16'h0)
      chk("slot_reg_addr", {27'h0, slot_reg_addr}, {27'h0, cur.ra});
    if (cur.wr != 16'h0)
      chk("slot_wr_data", slot_wr_data, cur.wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b0, 21'h0, 32'h0, 16'h0, 1'b0, 32'h0);
  endtask

  task automatic rd_hub(input int r, input logic [31:0] exp);
    step(1'b1, 1'b1, 1'b0, HUB + 21'(r), 32'h0, 16'h0, 1'b1, exp);
  endtask

  task automatic wr_hub(input int r, input logic [31:0] d);
    step(1'b1, 1'b0, 1'b1, HUB + 21'(r), d, 16'h0, 1'b0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (mmio_rd_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_valid_unexpected got=1 exp=0");
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("rd_data", mmio_rd_data, e.d);
          chk("rd_latency", 32'(cyc), 32'(e.due));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        rsp_t e;
        e = sb.pop_front();
        tests++;
        fails++;
        $display("FAIL rd_valid_missing got=0 exp=1 data=%h", e.d);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1);
  end

  vec_t vec[8];

  initial begin
    for (int i = 0; i < 16; i++)
      slot_rd_data[32*i +: 32] = 32'hA5A5_0000 | 32'(i);
    prev_s = '{16'h0, 16'h0, 16'h0, 5'h0, 32'h0};

    vec[0] = '{1, 1, 0, A(3, 2),  32'h0,         16'h0008, 1, 32'hA5A5_0003};
    vec[1] = '{1, 1, 0, A(0, 0),  32'h0,         16'h0001, 1, 32'hA5A5_0000};
    vec[2] = '{1, 0, 1, A(5, 7),  32'h1234_5678, 16'h0020, 0, 32'h0};
    vec[3] = '{1, 1, 0, A(8, 31), 32'h0,         16'h0100, 1, 32'hA5A5_0008};
    vec[4] = '{1, 1, 0, A(4, 1),  32'h0,         16'h0010, 1, 32'hA5A5_0004};
    vec[5] = '{0, 1, 0, A(3, 0),  32'h0,         16'h0000, 0, 32'h0};
    vec[6] = '{1, 0, 0, A(3, 0),  32'h0,         16'h0000, 0, 32'h0};
    vec[7] = '{1, 1, 0, A(1, 3),  32'h0,         16'h0002, 1, 32'hA5A5_0001};

    // reset with a read held on the bus
    reset = 1'b0;
    mmio_cs = 1'b1;
    mmio_rd = 1'b1;
    mmio_wr = 1'b0;
    mmio_addr = A(3, 2);
    mmio_wr_data = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_slot_cs", {16'h0, slot_cs}, 32'h0);
    chk("reset_slot_rd", {16'h0, slot_rd}, 32'h0);
    chk("reset_rd_valid", {31'h0, mmio_rd_valid}, 32'h0);
    chk("reset_rd_data", mmio_rd_data, 32'h0);
    chk("reset_err_irq", {31'h0, err_irq}, 32'h0);
    mmio_cs = 1'b0;
    mmio_rd = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    idle(2);
    chk("post_reset_err_irq", {31'h0, err_irq}, 32'h0);
    rd_hub(3, 32'(exp_acc));
    rd_hub(2, 32'h0);

    // mapped traffic, back to back
    for (int i = 0; i < 8; i++)
      step(vec[i].cs, vec[i].rd, vec[i].wr, vec[i].addr, vec[i].wd,
           vec[i].ecs, vec[i].ersp, vec[i].edata);
    idle(2);

    // unmapped slot 9 write then read
    step(1, 0, 1, A(9, 4), 32'hDEAD_BEEF, 16'h0, 0, 32'h0);
    step(1, 1, 0, A(9, 0), 32'h0, 16'h0, 1, 32'hFFFF_FFFF);
    idle(1);
    chk("unmapped_err_irq", {31'h0, err_irq}, 32'h1);
    rd_hub(0, 32'h1);
    rd_hub(2, 32'h2);
    rd_hub(1, 32'(A(9, 4)));
    // nonzero upper address bit
    step(1, 1, 0, 21'h10_0000 | A(3, 0), 32'h0, 16'h0, 1, 32'hFFFF_FFFF);

    // clear sticky, then a fresh error reloads ERR_ADDR
    wr_hub(0, 32'h1);
    idle(1);
    chk("w1c_err_irq", {31'h0, err_irq}, 32'h0);
    step(1, 1, 0, A(6, 1), 32'h0, 16'h0, 1, 32'hFFFF_FFFF);
    idle(1);
    chk("reerr_err_irq", {31'h0, err_irq}, 32'h1);
    rd_hub(1, 32'(A(6, 1)));
    step(1, 1, 0, A(7, 0), 32'h0, 16'h0, 1, 32'hFFFF_FFFF);
    rd_hub(1, 32'(A(6, 1)));
    rd_hub(2, 32'd5);
    rd_hub(0, 32'h1);

    // rd and wr together on a mapped slot
    step(1, 1, 1, A(2, 0), 32'h5555_AAAA, 16'h0, 1, 32'hFFFF_FFFF);
    rd_hub(2, 32'd6);

    // access counter and its clear
    rd_hub(3, 32'(exp_acc));
    wr_hub(3, 32'h0);
    exp_acc = 0;
    rd_hub(3, 32'(exp_acc));

    // error counter saturation
    wr_hub(2, 32'h0);
    for (int i = 0; i < 65540; i++)
      step(1, 0, 1, A(10, 0), 32'(i), 16'h0, 0, 32'h0);
    rd_hub(2, 32'h0000_FFFF);
    rd_hub(0, 32'h3);
    chk("sat_err_irq", {31'h0, err_irq}, 32'h1);
    wr_hub(0, 32'h2);
    rd_hub(0, 32'h1);
    rd_hub(2, 32'h0000_FFFF);
    idle(3);

    // reset during a pending read drops the response
    step(1, 1, 0, A(3, 2), 32'h0, 16'h0008, 0, 32'h0);
    reset = 1'b0;
    mmio_cs = 1'b0;
    mmio_rd = 1'b0;
    prev_s = '{16'h0, 16'h0, 16'h0, 5'h0, 32'h0};
    @(negedge clk);
    chk("rst2_rd_valid", {31'h0, mmio_rd_valid}, 32'h0);
    chk("rst2_slot_cs", {16'h0, slot_cs}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    idle(4);
    chk("rst2_rd_data", mmio_rd_data, 32'h0);
    chk("rst2_err_irq", {31'h0, err_irq}, 32'h0);
    exp_acc = 0;
    rd_hub(3, 32'h0);
    rd_hub(2, 32'h0);

    idle(4);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmio_hub_gen.md
Name: mmio_hub_gen

Overview:
- Parametrised successor to the fixed 64-slot MMIO controller. Decodes FPro-bus MMIO accesses into N_SLOT slot strobes.
- Returns registered read data with an explicit valid strobe.
- Detects accesses to unpopulated slots and illegal accesses, and logs them in a built-in hub status slot.
- Sits between the FPro bus bridge and the IO cores (timer, UART, GPIO, XADC, seven-segment, user cores).

Parameters:
- N_SLOT, 16, number of slots; power of 2, range 2..64.
- REG_AW, 5, register address bits per slot.
- SLOT_MASK, 16'h013F, bit i=1 means slot i is populated. The hub slot is always treated as populated.
- HUB_SLOT, N_SLOT-1, slot index of the internal status registers.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- mmio_cs  in  1  bus select
- mmio_wr  in  1  write strobe
- mmio_rd  in  1  read strobe
- mmio_addr  in  21  word address; bits [REG_AW-1:0] are the register, next log2(N_SLOT) bits are the slot, remaining bits must be 0
- mmio_wr_data  in  32  write data
- mmio_rd_data  out  32  registered read data
- mmio_rd_valid  out  1  one-cycle pulse when mmio_rd_data is valid
- slot_cs  out  N_SLOT  one-hot slot select
- slot_rd  out  N_SLOT  per-slot read strobe
- slot_wr  out  N_SLOT  per-slot write strobe
- slot_reg_addr  out  REG_AW  register address, shared by all slots
- slot_wr_data  out  32  write data, broadcast to all slots
- slot_rd_data  in  N_SLOT*32  flattened read data; slot i occupies bits [32i+31:32i]
- err_irq  out  1  level output; equals the sticky error bit

Behaviour:
- Access: legal when mmio_cs=1 and exactly one of mmio_rd/mmio_wr is 1.
- Illegal access: mmio_cs=1 with mmio_rd=mmio_wr=1.
  - No slot strobe is asserted.
  - Logged as an error.
  - A read response of 32'hFFFFFFFF with mmio_rd_valid is returned.
- Unmapped access: slot index not set in SLOT_MASK, or any upper address bit nonzero.
  - No slot strobe.
  - Logged as an error.
  - A read returns 32'hFFFFFFFF.
  - A write is discarded.
- Mapped access: slot_cs, slot_rd/slot_wr bit, slot_reg_addr and slot_wr_data follow the bus combinationally in the same cycle (strobe cycle T).
- Read latency: hub captures slot_rd_data of the selected slot at the T clock edge; mmio_rd_data and mmio_rd_valid are presented in T+1.
- Back-to-back reads every cycle are supported.
- mmio_rd_data holds its value between responses.
- Hub slot registers (reads return 0 in unused bits):
  - reg0 STATUS: bit0 = sticky error; bit1 = error-count saturated. Write-1-to-clear per bit.
  - reg1 ERR_ADDR: mmio_addr of the first error since the last clear, zero-extended.
  - reg2 ERR_CNT: 16-bit error count, saturating at 16'hFFFF, which sets bit1. Any write clears it.
  - reg3 ACC_CNT: 32-bit count of legal accesses, wraps. Any write clears it.
  - reg4..: read 0, writes ignored.
- Simultaneous W1C of STATUS and a new error in the same cycle: the error wins and the bit stays 1. ERR_ADDR is reloaded.
- Reset (asynchronous, reset=0): all registers clear.
  - mmio_rd_data=0, mmio_rd_valid=0, err_irq=0, all counters 0.
  - slot_* strobes are 0 while reset is low.
- Reset asserted during a pending read: the response is dropped; no valid pulse after reset releases.

Optional Feature:
- Macro: MMIO_HUB_PIPE_EN.
- Defined: an input register stage captures cs/rd/wr/addr/wr_data.
  - All slot strobes assert in T+1.
  - Read data is returned in T+2 (latency 2).
  - Write/read ordering is preserved.
  - Back-to-back throughput is 1 access/cycle.
- Undefined: combinational decode, read latency 1 as above.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> mmio_rd_valid=0, err_irq=0; hub reg2 and reg3 read 0.
- Mapped read: slot 3 drives 32'hA5A5_0003; read addr slot3/reg2 -> slot_rd[3] pulse in T, slot_reg_addr=2; mmio_rd_data=32'hA5A5_0003 with valid at T+1 (T+2 with MMIO_HUB_PIPE_EN).
- Unmapped: write to slot 9, then read from slot 9 (SLOT_MASK=16'h013F) -> no slot strobes; read returns 32'hFFFFFFFF; reg0=1, reg2=2, reg1=address of the write; err_irq=1.
- W1C race: write 1 to reg0 in the same cycle an unmapped read is issued on the following access... → write reg0=1 -> err_irq=0; then unmapped access -> err_irq=1.
- Illegal rd+wr asserted together on slot 2 -> slot_rd=slot_wr=0; response 32'hFFFFFFFF; ERR_CNT increments by 1.
- Saturation: force 65 540 unmapped accesses -> reg2=16'hFFFF, reg0=3; back-to-back reads of 4 slots every cycle -> 4 valid pulses in order, ACC_CNT increases by 4.
